// File: rtl/apb_slave_mem_param_if.sv
// APB bus bundle shared by the master and every apb_slave_mem_param instance.
interface apb_slave_mem_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_mem_param.sv
// APB slave with an embedded word-addressed memory, byte strobes, slave-ID
// decode in the top address bits, programmable wait states and error
// responses for out-of-range or misaligned accesses.
module apb_slave_mem_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int ID_W        = 2,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ID_W-1:0]        id,
  apb_slave_mem_param_if.slave   bus
);

  localparam int LANES  = DATA_W / 8;
  localparam int OFF_W  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W  = ADDR_W - ID_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 4;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 write_q, write_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [LANES-1:0]     strb_q,  strb_d;
  logic                 err_q,   err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mem_we;

  logic [DATA_W-1:0]    mem_q [DEPTH];

  // Request decode from the live bus (only meaningful in the setup cycle).
  logic [ID_W-1:0]      req_id;
  logic [IDX_W-1:0]     req_idx;
  logic                 req_hit;
  logic                 req_misalign;
  logic                 req_range_err;
  logic                 req_err;
  logic                 ready;

  assign req_id        = bus.paddr[ADDR_W-1 -: ID_W];
  assign req_idx       = IDX_W'(bus.paddr >> OFF_W);
  assign req_hit       = bus.psel && (req_id == id);
  assign req_misalign  = |(bus.paddr & OFF_MASK);
  assign req_range_err = 32'(req_idx) >= DEPTH;
  assign req_err       = req_misalign || req_range_err;

  // Next-state and datapath control for the IDLE/ACCESS transfer FSM.
  // NOTE: every signal gets its hold value before the case so no path can
  // leave one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A setup phase is psel with penable low; penable alone is ignored.
        if (req_hit && !bus.penable) begin
          write_d = bus.pwrite;
          idx_d   = req_idx;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          err_d   = req_err;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (!bus.pwrite && !req_err) begin
            rdata_d = mem_q[req_idx[MEM_AW-1:0]];
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          // Master abandoned the transfer: nothing is committed.
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          mem_we  = write_q && !err_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // State and latched-request registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-lane write into the memory array; reset blocks a coinciding commit.
  // NOTE: the array has no reset branch on purpose: contents survive reset
  // and the storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < LANES; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q[MEM_AW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // Response outputs are forced low while reset is asserted.
  assign ready       = (state_q == ACCESS) && (cnt_q == '0) && !reset;
  assign bus.pready  = ready;
  assign bus.pslverr = err_q && ready;
  assign bus.prdata  = (ready && !write_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_slave_mem_param.sv
// Directed bench for apb_slave_mem_param: DATA_W=32, ADDR_W=12, ID_W=2,
// DEPTH=200, WAIT_STATES=2, slave id 2'b01.
module tb_apb_slave_mem_param;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] id = 2'b01;

  apb_slave_mem_param_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  apb_slave_mem_param #(
    .DATA_W(32), .ADDR_W(12), .ID_W(2), .DEPTH(200), .WAIT_STATES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .id    (id),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
  endtask

  // Runs one transfer starting right after a rising edge; returns right after
  // the edge that closes it, so a following call is back-to-back. During the
  // access phase address, data and direction are scrambled to show they are
  // ignored. rdy_cyc is the first cycle (setup = 1) with pready high, 0 if none.
  task automatic xfer(input logic wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err,
                      output int rdy_cyc);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    bus.pstrb   = strb;
    rdy_cyc = 0;
    rd      = '0;
    err     = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.pready && rdy_cyc == 0) begin
        rdy_cyc = c;
        rd      = bus.prdata;
        err     = bus.pslverr;
      end
      @(posedge clk);
      #1;
      bus.penable = 1'b1;
      if (c == 1) begin
        bus.pwdata = ~data;
        bus.paddr  = addr ^ 12'h004;
        bus.pwrite = ~wr;
      end
      if (rdy_cyc != 0) break;
    end
    bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", bus.pready); end
      checks++; if (bus.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", bus.pslverr); end
      checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", bus.prdata); end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.paddr = 12'h408;
      @(negedge clk);
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL idle_pready: got %b want 0", bus.pready); end
      checks++; if (bus.pslverr !== 1'b0) begin errors++; $display("FAIL idle_pslverr: got %b want 0", bus.pslverr); end
      checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL idle_prdata: got %h want 0", bus.prdata); end
      @(posedge clk);
      #1;
    end
    bus_idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b1, 12'h408, 32'hDEADBEEF, 4'hF, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL wr_ready_cycle: got %0d want 4", rc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_pslverr: got %b want 0", err); end
    @(negedge clk);
    checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL wr_ready_after: got %b want 0", bus.pready); end
    @(posedge clk);
    #1;
    xfer(1'b0, 12'h408, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL rd_ready_cycle: got %0d want 4", rc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_pslverr: got %b want 0", err); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b1, 12'h40C, 32'h11223344, 4'hF, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL strb_full_ready: got %0d want 4", rc); end
    xfer(1'b1, 12'h40C, 32'hAABBCCDD, 4'b0101, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL strb_part_ready: got %0d want 4", rc); end
    xfer(1'b0, 12'h40C, 32'h0, 4'hF, rd, err, rc);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_data: got %h want 11bb33dd", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb_pslverr: got %b want 0", err); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b1, 12'h400, 32'hCAFEF00D, 4'hF, rd, err, rc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_w0_pslverr: got %b want 0", err); end
    xfer(1'b1, 12'h720, 32'hFFFFFFFF, 4'hF, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL err_range_ready: got %0d want 4", rc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_range_pslverr: got %b want 1", err); end
    xfer(1'b1, 12'h402, 32'hFFFFFFFF, 4'hF, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL err_align_ready: got %0d want 4", rc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_align_pslverr: got %b want 1", err); end
    xfer(1'b0, 12'h720, 32'h0, 4'h0, rd, err, rc);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_rd_pslverr: got %b want 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_prdata: got %h want 0", rd); end
    xfer(1'b0, 12'h400, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL err_w0_kept: got %h want cafef00d", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_w0_rd_pslverr: got %b want 0", err); end
  endtask

  task automatic test_no_hit();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b0, 12'h808, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rc !== 0) begin errors++; $display("FAIL nohit_ready: got cycle %0d want none", rc); end
    @(posedge clk);
    #1;
    xfer(1'b0, 12'h408, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL nohit_after_ready: got %0d want 4", rc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL nohit_after_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b1, 12'h410, 32'h0BADF00D, 4'hF, rd, err, rc);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 12'h410; bus.pwdata = 32'h55; bus.pstrb = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL abort_pready c%0d: got %b want 0", c, bus.pready); end
      @(posedge clk);
      #1;
      bus.penable = 1'b1;
      if (c >= 2) bus_idle();
    end
    xfer(1'b0, 12'h410, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_kept: got %h want 0badf00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b1, 12'h414, 32'h12345678, 4'hF, rd, err, rc);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 12'h414; bus.pwdata = 32'h77; bus.pstrb = 4'hF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL rstmid_pready c%0d: got %b want 0", c, bus.pready); end
      @(posedge clk);
      #1;
      bus.penable = 1'b1;
      if (c == 3) reset = 1'b1;
      if (c == 4) begin reset = 1'b0; bus_idle(); end
    end
    xfer(1'b0, 12'h414, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL rstmid_rd_ready: got %0d want 4", rc); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rstmid_kept: got %h want 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int rc;
    xfer(1'b1, 12'h418, 32'h0F0F0F0F, 4'hF, rd, err, rc);
    xfer(1'b0, 12'h418, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rc !== 4) begin errors++; $display("FAIL b2b_ready: got %0d want 4", rc); end
    checks++; if (rd !== 32'h0F0F0F0F) begin errors++; $display("FAIL b2b_data: got %h want 0f0f0f0f", rd); end
    xfer(1'b1, 12'h418, 32'hA5A5A5A5, 4'hF, rd, err, rc);
    xfer(1'b0, 12'h418, 32'h0, 4'h0, rd, err, rc);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_raw: got %h want a5a5a5a5", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_error();
    test_no_hit();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
